// File: rtl/game_pkg.sv
// Shared types and widths for the game sequencer and its helpers.
package game_pkg;

    localparam int STATE_W = 2;
    localparam int LIVES_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HIT  = 2'd2,
        OVER = 2'd3
    } game_state_t;

endpackage

// File: rtl/game_sequencer_rr_free_picker.sv
// Round-robin first-free finder: returns a one-hot grant for the first
// asteroid slot whose enable bit is low, scanning upward from ptr with wrap.
module rr_free_picker #(
    parameter int N     = 10,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     mask,
    input  logic [PTR_W-1:0] ptr,
    output logic             found,
    output logic [N-1:0]     grant
);

    // The free vector is laid out twice so a linear priority scan starting
    // at ptr naturally wraps into the second copy.
    logic [2*N-1:0] dbl;
    logic [2*N-1:0] cand;
    logic [2*N-1:0] hit;

    genvar gi;

    generate
        for (gi = 0; gi < N; gi++) begin : g_dbl
            assign dbl[gi]     = ~mask[gi];
            assign dbl[gi + N] = ~mask[gi];
        end

        for (gi = 0; gi < 2 * N; gi++) begin : g_scan
            // Positions strictly below gi; a candidate wins only if none of
            // those is also a candidate.
            localparam logic [2*N-1:0] BELOW = {(2 * N){1'b1}} >> (2 * N - gi);
            assign cand[gi] = dbl[gi] & ({1'b0, ptr} <= (PTR_W + 1)'(gi));
            assign hit[gi]  = cand[gi] & ~(|(cand & BELOW));
        end

        for (gi = 0; gi < N; gi++) begin : g_fold
            assign grant[gi] = hit[gi] | hit[gi + N];
        end
    endgenerate

    assign found = |cand;

endmodule

// File: rtl/game_sequencer.sv
// Frame-rate game controller: state machine, lives, saturating score and
// round-robin asteroid spawn scheduling. All decisions are taken on frame.
module game_sequencer
    import game_pkg::*;
#(
    parameter int ASTEROID_COUNT = 10,
    parameter int LIVES          = 3,
    parameter int SPAWN_PERIOD   = 60,
    parameter int HIT_FRAMES     = 120,
    parameter int SCORE_W        = 10,
    parameter int MAX_SCORE      = 999
) (
    input  logic                      clk_pix,
    input  logic                      rst,
    input  logic                      frame,
    input  logic                      start,
    input  logic                      collision,
    input  logic [ASTEROID_COUNT-1:0] asteroid_shot,
    input  logic [ASTEROID_COUNT-1:0] asteroid_enabled,
    output logic [ASTEROID_COUNT-1:0] asteroid_spawn,
    output logic                      play_en,
    output logic                      blink,
    output logic                      game_over,
    output logic [STATE_W-1:0]        state,
    output logic [SCORE_W-1:0]        score,
    output logic [LIVES_W-1:0]        lives
);

    localparam int PTR_W   = (ASTEROID_COUNT > 1) ? $clog2(ASTEROID_COUNT) : 1;
    localparam int PC_W    = $clog2(ASTEROID_COUNT + 1);
    localparam int SPAWN_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
    // Keep at least four bits so the blink tap hit_cnt[3] always exists.
    localparam int HIT_W   = ($clog2(HIT_FRAMES) > 4) ? $clog2(HIT_FRAMES) : 4;

    localparam logic [SPAWN_W-1:0] SPAWN_RELOAD = SPAWN_W'(SPAWN_PERIOD - 1);
    localparam logic [HIT_W-1:0]   HIT_RELOAD   = HIT_W'(HIT_FRAMES - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT   = LIVES_W'(LIVES);
    localparam logic [SCORE_W:0]   SCORE_CAP    = (SCORE_W + 1)'(MAX_SCORE);

    function automatic logic [PC_W-1:0] popcount(input logic [ASTEROID_COUNT-1:0] v);
        return PC_W'($countones(v));
    endfunction

    game_state_t               state_reg, state_next;
    logic [SCORE_W-1:0]        score_reg, score_next;
    logic [LIVES_W-1:0]        lives_reg, lives_next;
    logic [SPAWN_W-1:0]        spawn_cnt_reg, spawn_cnt_next;
    logic [HIT_W-1:0]          hit_cnt_reg, hit_cnt_next;
    logic [PTR_W-1:0]          rr_ptr_reg, rr_ptr_next;
    logic                      start_d_reg;
    logic                      start_pending_reg, start_pending_next;
    logic [ASTEROID_COUNT-1:0] spawn_reg, spawn_next;
    logic                      play_en_reg, play_en_next;
    logic                      blink_reg, blink_next;
    logic                      game_over_reg, game_over_next;

    logic                      start_edge;
    logic [SCORE_W:0]          score_sum;
    logic [SCORE_W-1:0]        score_acc;
    logic                      free_found;
    logic [ASTEROID_COUNT-1:0] free_grant;
    logic [PTR_W-1:0]          grant_next_ptr;

    rr_free_picker #(
        .N     (ASTEROID_COUNT),
        .PTR_W (PTR_W)
    ) u_picker (
        .mask  (asteroid_enabled),
        .ptr   (rr_ptr_reg),
        .found (free_found),
        .grant (free_grant)
    );

    // Pointer to the slot just after the granted one, wrapping to zero.
    always_comb begin
        grant_next_ptr = '0;
        for (int i = 0; i < ASTEROID_COUNT; i++) begin
            if (free_grant[i]) begin
                grant_next_ptr = PTR_W'((i + 1) % ASTEROID_COUNT);
            end
        end
    end

    // Next-state, score/lives bookkeeping and spawn scheduling.
    always_comb begin
        state_next         = state_reg;
        score_next         = score_reg;
        lives_next         = lives_reg;
        spawn_cnt_next     = spawn_cnt_reg;
        hit_cnt_next       = hit_cnt_reg;
        rr_ptr_next        = rr_ptr_reg;
        spawn_next         = '0;

        start_edge         = start & ~start_d_reg;
        start_pending_next = start_pending_reg | start_edge;

        // Sum one bit wider than the score so the clamp sees the overflow.
        score_sum = {1'b0, score_reg} + (SCORE_W + 1)'(popcount(asteroid_shot));
        score_acc = (score_sum > SCORE_CAP) ? SCORE_CAP[SCORE_W-1:0] : score_sum[SCORE_W-1:0];

        case (state_reg)
            IDLE: begin
                if (frame) begin
                    score_next         = '0;
                    lives_next         = LIVES_INIT;
                    // An edge arriving on the frame cycle itself waits for the next frame.
                    start_pending_next = start_edge;
                    if (start_pending_reg) begin
                        state_next     = PLAY;
                        spawn_cnt_next = SPAWN_RELOAD;
                        rr_ptr_next    = '0;
                    end
                end
            end

            PLAY: begin
                // Start presses during a game have no effect.
                start_pending_next = 1'b0;
                if (frame) begin
                    score_next = score_acc;
                    if (collision) begin
                        lives_next = lives_reg - 1'b1;
                        if (lives_reg == LIVES_W'(1)) begin
                            state_next = OVER;
                        end else begin
                            state_next   = HIT;
                            hit_cnt_next = HIT_RELOAD;
                        end
                    end
                    if (spawn_cnt_reg != '0) begin
                        spawn_cnt_next = spawn_cnt_reg - 1'b1;
                    end else if (free_found) begin
                        spawn_next     = free_grant;
                        rr_ptr_next    = grant_next_ptr;
                        spawn_cnt_next = SPAWN_RELOAD;
                    end
                end
            end

            HIT: begin
                start_pending_next = 1'b0;
                if (frame) begin
                    score_next = score_acc;
                    if (hit_cnt_reg == '0) begin
                        state_next = PLAY;
                    end else begin
                        hit_cnt_next = hit_cnt_reg - 1'b1;
                    end
                end
            end

            OVER: begin
                if (frame) begin
                    start_pending_next = start_edge;
                    if (start_pending_reg) begin
                        state_next     = PLAY;
                        score_next     = '0;
                        lives_next     = LIVES_INIT;
                        spawn_cnt_next = SPAWN_RELOAD;
                        rr_ptr_next    = '0;
                    end
                end
            end

            default: state_next = IDLE;
        endcase

        play_en_next   = (state_next == PLAY) || (state_next == HIT);
        game_over_next = (state_next == OVER);
        blink_next     = (state_next == HIT) && hit_cnt_next[3];
    end

    // State and output registers; reset wins over a coincident frame.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            state_reg         <= IDLE;
            score_reg         <= '0;
            lives_reg         <= LIVES_INIT;
            spawn_cnt_reg     <= SPAWN_RELOAD;
            hit_cnt_reg       <= '0;
            rr_ptr_reg        <= '0;
            start_d_reg       <= 1'b0;
            start_pending_reg <= 1'b0;
            spawn_reg         <= '0;
            play_en_reg       <= 1'b0;
            blink_reg         <= 1'b0;
            game_over_reg     <= 1'b0;
        end else begin
            state_reg         <= state_next;
            score_reg         <= score_next;
            lives_reg         <= lives_next;
            spawn_cnt_reg     <= spawn_cnt_next;
            hit_cnt_reg       <= hit_cnt_next;
            rr_ptr_reg        <= rr_ptr_next;
            start_d_reg       <= start;
            start_pending_reg <= start_pending_next;
            spawn_reg         <= spawn_next;
            play_en_reg       <= play_en_next;
            blink_reg         <= blink_next;
            game_over_reg     <= game_over_next;
        end
    end

    assign state          = state_reg;
    assign score          = score_reg;
    assign lives          = lives_reg;
    assign asteroid_spawn = spawn_reg;
    assign play_en        = play_en_reg;
    assign blink          = blink_reg;
    assign game_over      = game_over_reg;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer (SPAWN_PERIOD=1 so every
// frame in PLAY is a spawn attempt).
module tb_game_sequencer;
    import game_pkg::*;

    localparam int N = 10;

    logic         clk_pix = 1'b0;
    logic         rst = 1'b1;
    logic         frame = 1'b0;
    logic         start = 1'b0;
    logic         collision = 1'b0;
    logic [N-1:0] asteroid_shot = '0;
    logic [N-1:0] asteroid_enabled = '1;
    logic [N-1:0] asteroid_spawn;
    logic         play_en;
    logic         blink;
    logic         game_over;
    logic [1:0]   state;
    logic [9:0]   score;
    logic [1:0]   lives;

    int checks = 0;
    int errors = 0;
    int frames = 0;

    game_sequencer #(
        .ASTEROID_COUNT (N),
        .LIVES          (3),
        .SPAWN_PERIOD   (1),
        .HIT_FRAMES     (120),
        .SCORE_W        (10),
        .MAX_SCORE      (999)
    ) dut (
        .clk_pix          (clk_pix),
        .rst              (rst),
        .frame            (frame),
        .start            (start),
        .collision        (collision),
        .asteroid_shot    (asteroid_shot),
        .asteroid_enabled (asteroid_enabled),
        .asteroid_spawn   (asteroid_spawn),
        .play_en          (play_en),
        .blink            (blink),
        .game_over        (game_over),
        .state            (state),
        .score            (score),
        .lives            (lives)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One-cycle frame pulse; returns on the falling edge after the update.
    task automatic do_frame();
        @(negedge clk_pix);
        frame = 1'b1;
        @(negedge clk_pix);
        frame = 1'b0;
        frames++;
        $display("frame %0d: coll=%0b shot=%b en=%b -> state=%0d score=%0d lives=%0d spawn=%b blink=%0b",
                 frames, collision, asteroid_shot, asteroid_enabled, state, score, lives,
                 asteroid_spawn, blink);
    endtask

    task automatic start_press();
        @(negedge clk_pix);
        start = 1'b1;
        @(negedge clk_pix);
        start = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk_pix);
        rst = 1'b0;
        check("rst_state", 32'(state), 32'(IDLE));
        check("rst_score", 32'(score), 32'd0);
        check("rst_lives", 32'(lives), 32'd3);
        check("rst_play_en", 32'(play_en), 32'd0);
        check("rst_game_over", 32'(game_over), 32'd0);
        check("rst_spawn", 32'(asteroid_spawn), 32'd0);

        // Frame without a start press keeps IDLE
        do_frame();
        check("idle_hold", 32'(state), 32'(IDLE));

        // Start edge then frame enters PLAY
        start_press();
        do_frame();
        check("start_state", 32'(state), 32'(PLAY));
        check("start_score", 32'(score), 32'd0);
        check("start_lives", 32'(lives), 32'd3);
        check("start_play_en", 32'(play_en), 32'd1);
        check("start_no_spawn", 32'(asteroid_spawn), 32'd0);

        // Round-robin spawns from slot 0
        asteroid_enabled = '0;
        do_frame();
        check("spawn0", 32'(asteroid_spawn), 32'h001);
        @(negedge clk_pix);
        check("spawn0_pulse", 32'(asteroid_spawn), 32'h000);
        asteroid_enabled = 10'h001;
        do_frame();
        check("spawn1", 32'(asteroid_spawn), 32'h002);

        // All enabled: no spawn, retries each frame
        asteroid_enabled = 10'h3FF;
        do_frame();
        check("spawn_full_a", 32'(asteroid_spawn), 32'h000);
        do_frame();
        check("spawn_full_b", 32'(asteroid_spawn), 32'h000);
        asteroid_enabled = 10'h3EF;
        do_frame();
        check("spawn4", 32'(asteroid_spawn), 32'h010);
        // Pointer now 5: slot 6 wins over slot 3
        asteroid_enabled = 10'h3B7;
        do_frame();
        check("spawn6", 32'(asteroid_spawn), 32'h040);
        asteroid_enabled = 10'h3FF;

        // First collision: lives 3 -> 2, HIT
        collision = 1'b1;
        do_frame();
        check("hit1_state", 32'(state), 32'(HIT));
        check("hit1_lives", 32'(lives), 32'd2);
        check("hit1_blink", 32'(blink), 32'd0);
        asteroid_enabled = '0;
        for (int k = 1; k <= 119; k++) begin
            do_frame();
            check("hit1_lives_hold", 32'(lives), 32'd2);
            check("hit1_state_hold", 32'(state), 32'(HIT));
            check("hit1_no_spawn", 32'(asteroid_spawn), 32'd0);
            if (k == 1) check("hit1_blink_off", 32'(blink), 32'd0);
            if (k == 8) check("hit1_blink_on", 32'(blink), 32'd1);
        end
        do_frame();
        check("hit1_exit_state", 32'(state), 32'(PLAY));
        check("hit1_exit_lives", 32'(lives), 32'd2);
        check("hit1_exit_blink", 32'(blink), 32'd0);
        collision = 1'b0;
        asteroid_enabled = '1;

        // Second collision: lives 2 -> 1, then sit out the HIT window
        collision = 1'b1;
        do_frame();
        collision = 1'b0;
        check("hit2_lives", 32'(lives), 32'd1);
        repeat (120) do_frame();
        check("hit2_exit_state", 32'(state), 32'(PLAY));

        // Score 5, then last-life collision with 2 shots
        asteroid_shot = 10'h01F;
        do_frame();
        check("score5", 32'(score), 32'd5);
        asteroid_shot = 10'h003;
        collision = 1'b1;
        do_frame();
        asteroid_shot = '0;
        collision = 1'b0;
        check("over_state", 32'(state), 32'(OVER));
        check("over_lives", 32'(lives), 32'd0);
        check("over_score", 32'(score), 32'd7);
        check("over_flag", 32'(game_over), 32'd1);
        check("over_play_en", 32'(play_en), 32'd0);
        do_frame();
        check("over_hold_state", 32'(state), 32'(OVER));
        check("over_hold_score", 32'(score), 32'd7);

        // Restart from OVER
        start_press();
        do_frame();
        check("restart_state", 32'(state), 32'(PLAY));
        check("restart_score", 32'(score), 32'd0);
        check("restart_lives", 32'(lives), 32'd3);
        check("restart_game_over", 32'(game_over), 32'd0);

        // Saturating score
        asteroid_shot = 10'h3FF;
        repeat (99) do_frame();
        check("score990", 32'(score), 32'd990);
        asteroid_shot = 10'h07F;
        do_frame();
        check("score997", 32'(score), 32'd997);
        asteroid_shot = 10'h016;
        do_frame();
        check("score_sat", 32'(score), 32'd999);
        asteroid_shot = 10'h001;
        do_frame();
        check("score_sat_hold", 32'(score), 32'd999);
        asteroid_shot = '0;

        // Reset coincident with frame while in HIT
        collision = 1'b1;
        do_frame();
        collision = 1'b0;
        check("pre_rst_state", 32'(state), 32'(HIT));
        asteroid_enabled = '0;
        @(negedge clk_pix);
        frame = 1'b1;
        rst = 1'b1;
        @(negedge clk_pix);
        frame = 1'b0;
        rst = 1'b0;
        check("midrst_state", 32'(state), 32'(IDLE));
        check("midrst_score", 32'(score), 32'd0);
        check("midrst_lives", 32'(lives), 32'd3);
        check("midrst_play_en", 32'(play_en), 32'd0);
        check("midrst_blink", 32'(blink), 32'd0);
        check("midrst_spawn", 32'(asteroid_spawn), 32'd0);
        @(negedge clk_pix);
        check("midrst_spawn_b", 32'(asteroid_spawn), 32'd0);
        do_frame();
        check("midrst_idle", 32'(state), 32'(IDLE));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
